// File: rtl/udp_arb_pkg.sv
// Shared definitions for the UDP TX payload arbiter.
//   arb_state_e            : arbiter FSM states
//   ABORT_BYTE             : filler byte that closes an aborted packet
//   DEFAULT_TIMEOUT_CYCLES : default idle-source limit before abort
package udp_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPass  = 2'd1,
    StAbort = 2'd2
  } arb_state_e;

  localparam logic [7:0]  ABORT_BYTE             = 8'h21;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector.
//   req_i  : request vector, one bit per source
//   last_i : index of the most recently served source
//   gnt_o  : one-hot grant (zero when nothing requests); search starts at last_i+1
module rr_select #(
  parameter int unsigned NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0]         req_i,
  input  logic [$clog2(NUM_SRC)-1:0] last_i,
  output logic [NUM_SRC-1:0]         gnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);

  always_comb begin
    logic found;
    int unsigned idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      idx = 32'(last_i) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && req_i[idx[IDX_W-1:0]]) begin
        gnt_o[idx[IDX_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet arbiter merging NUM_SRC AXI-stream byte sources into one UDP TX payload stream.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_s_tdata/tvalid/tlast  : per-source payload streams (source k on byte lane k)
//   o_s_tready              : per-source ready (only the granted source sees i_m_tready)
//   i_s_ip_adr/i_s_port_nbr : per-source destination header
//   o_m_tdata/tvalid/tlast  : merged stream, i_m_tready its downstream ready
//   o_m_ip_adr/o_m_port_nbr : header of the packet in flight, latched at grant
//   o_grant, o_busy         : current grant (one-hot, PASS only) and activity flag
//   o_abort, o_abort_cnt    : one-cycle pulse per aborted packet, saturating abort count
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_SRC*8-1:0]  i_s_tdata,
  input  logic [NUM_SRC-1:0]    i_s_tvalid,
  input  logic [NUM_SRC-1:0]    i_s_tlast,
  output logic [NUM_SRC-1:0]    o_s_tready,
  input  logic [NUM_SRC*32-1:0] i_s_ip_adr,
  input  logic [NUM_SRC*16-1:0] i_s_port_nbr,
  output logic [7:0]            o_m_tdata,
  output logic                  o_m_tvalid,
  output logic                  o_m_tlast,
  input  logic                  i_m_tready,
  output logic [31:0]           o_m_ip_adr,
  output logic [15:0]           o_m_port_nbr,
  output logic [NUM_SRC-1:0]    o_grant,
  output logic                  o_busy,
  output logic                  o_abort,
  output logic [15:0]           o_abort_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [31:0]        ip_q, ip_d;
  logic [15:0]        port_q, port_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [15:0]        abort_cnt_q, abort_cnt_d;
  logic               abort_q, abort_d;

  logic [NUM_SRC-1:0] rr_gnt;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   gidx;
  logic [7:0]         tdata_arr [NUM_SRC];
  logic [31:0]        ip_arr    [NUM_SRC];
  logic [15:0]        port_arr  [NUM_SRC];
  logic [7:0]         src_data;
  logic               src_valid;
  logic               src_last;

  rr_select #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_select (
    .req_i  (i_s_tvalid),
    .last_i (last_grant_q),
    .gnt_o  (rr_gnt)
  );

  // Unpack the flat per-source buses and encode the one-hot grants to indices.
  always_comb begin
    rr_idx = '0;
    gidx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      tdata_arr[k] = i_s_tdata[8*k +: 8];
      ip_arr[k]    = i_s_ip_adr[32*k +: 32];
      port_arr[k]  = i_s_port_nbr[16*k +: 16];
      if (rr_gnt[k])  rr_idx = IDX_W'(k);
      if (grant_q[k]) gidx   = IDX_W'(k);
    end
  end

  assign src_data  = tdata_arr[gidx];
  assign src_valid = i_s_tvalid[gidx];
  assign src_last  = i_s_tlast[gidx];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ip_d         = ip_q;
    port_d       = port_q;
    tmo_d        = tmo_q;
    abort_cnt_d  = abort_cnt_q;
    abort_d      = 1'b0;
    o_m_tdata    = '0;
    o_m_tvalid   = 1'b0;
    o_m_tlast    = 1'b0;
    o_s_tready   = '0;

    unique case (state_q)
      StIdle: begin
        if (|i_s_tvalid) begin
          state_d = StPass;
          grant_d = rr_gnt;
          ip_d    = ip_arr[rr_idx];
          port_d  = port_arr[rr_idx];
          tmo_d   = '0;
        end
      end

      StPass: begin
        o_m_tdata  = src_data;
        o_m_tvalid = src_valid;
        o_m_tlast  = src_last;
        o_s_tready = grant_q & {NUM_SRC{i_m_tready}};
        if (src_valid && i_m_tready) begin
          tmo_d = '0;
          if (src_last) begin
            state_d      = StIdle;
            last_grant_d = gidx;
          end
        end else if (!src_valid) begin
          // Only a silent source counts; downstream backpressure never does.
          tmo_d = tmo_q + 16'd1;
          if ({1'b0, tmo_q} + 17'd1 >= 17'(TIMEOUT_CYCLES)) state_d = StAbort;
        end
      end

      StAbort: begin
        o_m_tdata  = ABORT_BYTE;
        o_m_tvalid = 1'b1;
        o_m_tlast  = 1'b1;
        if (i_m_tready) begin
          abort_d      = 1'b1;
          last_grant_d = gidx;
          tmo_d        = '0;
          state_d      = StIdle;
          if (abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_SRC - 1);
      ip_q         <= '0;
      port_q       <= '0;
      tmo_q        <= '0;
      abort_cnt_q  <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ip_q         <= ip_d;
      port_q       <= port_d;
      tmo_q        <= tmo_d;
      abort_cnt_q  <= abort_cnt_d;
      abort_q      <= abort_d;
    end
  end

  // ABORT keeps the header but no source holds the grant any more.
  assign o_grant      = (state_q == StPass) ? grant_q : '0;
  assign o_busy       = (state_q != StIdle);
  assign o_abort      = abort_q;
  assign o_abort_cnt  = abort_cnt_q;
  assign o_m_ip_adr   = ip_q;
  assign o_m_port_nbr = port_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: source drivers consume per-source beat queues,
// tests push the hand-ordered expected output beats, a monitor pops and compares.
module tb_udp_tx_arbiter;

  localparam int NS  = 2;
  localparam int TMO = 8;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;   // >0: idle entry, source drops tvalid for gap-1 cycles
  } src_ent_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         src;
    bit         abort;
    int         gap;   // >0: required cycle distance from previous accepted beat
  } exp_ent_t;

  logic           i_clk;
  logic           i_rst_n;
  logic [NS*8-1:0]  i_s_tdata;
  logic [NS-1:0]    i_s_tvalid;
  logic [NS-1:0]    i_s_tlast;
  logic [NS-1:0]    o_s_tready;
  logic [NS*32-1:0] i_s_ip_adr;
  logic [NS*16-1:0] i_s_port_nbr;
  logic [7:0]     o_m_tdata;
  logic           o_m_tvalid;
  logic           o_m_tlast;
  logic           i_m_tready;
  logic [31:0]    o_m_ip_adr;
  logic [15:0]    o_m_port_nbr;
  logic [NS-1:0]  o_grant;
  logic           o_busy;
  logic           o_abort;
  logic [15:0]    o_abort_cnt;

  src_ent_t src_q [NS][$];
  exp_ent_t exp_q [$];
  int       rdy_mode;       // 0: ready high, 1: toggle, 2: held low
  int       total;
  int       bad;
  int       cyc;
  int       last_beat_cyc;
  int       abort_pulses;

  udp_tx_arbiter #(
    .NUM_SRC        (NS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_s_tdata    (i_s_tdata),
    .i_s_tvalid   (i_s_tvalid),
    .i_s_tlast    (i_s_tlast),
    .o_s_tready   (o_s_tready),
    .i_s_ip_adr   (i_s_ip_adr),
    .i_s_port_nbr (i_s_port_nbr),
    .o_m_tdata    (o_m_tdata),
    .o_m_tvalid   (o_m_tvalid),
    .o_m_tlast    (o_m_tlast),
    .i_m_tready   (i_m_tready),
    .o_m_ip_adr   (o_m_ip_adr),
    .o_m_port_nbr (o_m_port_nbr),
    .o_grant      (o_grant),
    .o_busy       (o_busy),
    .o_abort      (o_abort),
    .o_abort_cnt  (o_abort_cnt)
  );

  function automatic logic [31:0] ip_of(int k);
    return 32'hC0A8_0100 + 32'(k);
  endfunction

  function automatic logic [15:0] port_of(int k);
    return 16'd5000 + 16'(k);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic sbeat(int k, logic [7:0] d, logic l);
    src_ent_t e;
    e.data = d; e.last = l; e.gap = 0;
    src_q[k].push_back(e);
  endtask

  task automatic sgap(int k, int n);
    src_ent_t e;
    e.data = '0; e.last = 1'b0; e.gap = n;
    src_q[k].push_back(e);
  endtask

  task automatic ebeat(int k, logic [7:0] d, logic l, bit ab, int g);
    exp_ent_t e;
    e.data = d; e.last = l; e.src = k; e.abort = ab; e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || src_q[0].size() > 0 || src_q[1].size() > 0) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge i_clk);
  endtask

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Source and downstream-ready driver.
  initial begin
    logic [NS-1:0] fire;
    src_ent_t      t;
    i_s_tvalid = '0;
    i_s_tlast  = '0;
    i_s_tdata  = '0;
    i_m_tready = 1'b1;
    for (int k = 0; k < NS; k++) begin
      i_s_ip_adr[32*k +: 32]   = ip_of(k);
      i_s_port_nbr[16*k +: 16] = port_of(k);
    end
    forever begin
      @(negedge i_clk);
      fire = i_s_tvalid & o_s_tready;
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        0:       i_m_tready = 1'b1;
        1:       i_m_tready = ~i_m_tready;
        default: i_m_tready = 1'b0;
      endcase
      for (int k = 0; k < NS; k++) begin
        if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0 && src_q[k][0].gap > 0) begin
          t = src_q[k].pop_front();
          t.gap = t.gap - 1;
          if (t.gap > 0) src_q[k].push_front(t);
        end
        if (src_q[k].size() > 0 && src_q[k][0].gap == 0) begin
          i_s_tvalid[k]        = 1'b1;
          i_s_tlast[k]         = src_q[k][0].last;
          i_s_tdata[8*k +: 8]  = src_q[k][0].data;
        end else begin
          i_s_tvalid[k]        = 1'b0;
          i_s_tlast[k]         = 1'b0;
          i_s_tdata[8*k +: 8]  = '0;
        end
      end
    end
  end

  // Monitor: compare every accepted output beat against the scoreboard.
  initial begin
    exp_ent_t      e;
    logic [NS-1:0] g;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (o_abort) abort_pulses++;
      if (i_rst_n && o_m_tvalid && i_m_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h want no beat", o_m_tdata);
        end else begin
          e = exp_q.pop_front();
          g = '0;
          if (!e.abort) g[e.src] = 1'b1;
          chk("m_tdata", 64'(o_m_tdata), 64'(e.data));
          chk("m_tlast", 64'(o_m_tlast), 64'(e.last));
          chk("grant", 64'(o_grant), 64'(g));
          chk("ip_adr", 64'(o_m_ip_adr), 64'(ip_of(e.src)));
          chk("port_nbr", 64'(o_m_port_nbr), 64'(port_of(e.src)));
          if (e.gap > 0) chk("beat_spacing", 64'(cyc - last_beat_cyc), 64'(e.gap));
        end
        last_beat_cyc = cyc;
      end
    end
  end

  initial begin
    total = 0; bad = 0; cyc = 0; last_beat_cyc = 0; abort_pulses = 0; rdy_mode = 0;
    i_rst_n = 1'b0;
    #3;
    chk("rst_grant", 64'(o_grant), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_abort", 64'(o_abort), 64'd0);
    chk("rst_abort_cnt", 64'(o_abort_cnt), 64'd0);
    chk("rst_ip", 64'(o_m_ip_adr), 64'd0);
    chk("rst_port", 64'(o_m_port_nbr), 64'd0);
    chk("rst_tvalid", 64'(o_m_tvalid), 64'd0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Two simultaneous 3-byte packets: src0 first, one dead cycle, then src1.
    sbeat(0, 8'h11, 0); sbeat(0, 8'h22, 0); sbeat(0, 8'h33, 1);
    sbeat(1, 8'h44, 0); sbeat(1, 8'h55, 0); sbeat(1, 8'h66, 1);
    ebeat(0, 8'h11, 0, 0, 0); ebeat(0, 8'h22, 0, 0, 1); ebeat(0, 8'h33, 1, 0, 1);
    ebeat(1, 8'h44, 0, 0, 2); ebeat(1, 8'h55, 0, 0, 1); ebeat(1, 8'h66, 1, 0, 1);
    drain(200);

    // Toggling downstream ready, competing src1 must wait for src0's tlast.
    rdy_mode = 1;
    sbeat(0, 8'hAB, 0); sbeat(0, 8'hCD, 0); sbeat(0, 8'h12, 0); sbeat(0, 8'h34, 1);
    sbeat(1, 8'h77, 0); sbeat(1, 8'h88, 1);
    ebeat(0, 8'hAB, 0, 0, 0); ebeat(0, 8'hCD, 0, 0, 0);
    ebeat(0, 8'h12, 0, 0, 0); ebeat(0, 8'h34, 1, 0, 0);
    ebeat(1, 8'h77, 0, 0, 0); ebeat(1, 8'h88, 1, 0, 0);
    drain(200);
    rdy_mode = 0;
    repeat (2) @(negedge i_clk);

    // src0 goes silent mid-packet: abort byte closes it, then src1 is served.
    sbeat(0, 8'hA1, 0); sbeat(0, 8'hA2, 0); sgap(0, 30);
    sbeat(1, 8'hB1, 0); sbeat(1, 8'hB2, 1);
    ebeat(0, 8'hA1, 0, 0, 0); ebeat(0, 8'hA2, 0, 0, 1);
    ebeat(0, 8'h21, 1, 1, 0);
    ebeat(1, 8'hB1, 0, 0, 0); ebeat(1, 8'hB2, 1, 0, 1);
    drain(300);
    chk("abort_pulses", 64'(abort_pulses), 64'd1);
    chk("abort_cnt", 64'(o_abort_cnt), 64'd1);

    // Long downstream backpressure must never time out.
    rdy_mode = 2;
    repeat (2) @(negedge i_clk);
    sbeat(0, 8'hC1, 0); sbeat(0, 8'hC2, 1);
    ebeat(0, 8'hC1, 0, 0, 0); ebeat(0, 8'hC2, 1, 0, 1);
    repeat (5) @(negedge i_clk);
    chk("bp_tvalid", 64'(o_m_tvalid), 64'd1);
    chk("bp_tdata", 64'(o_m_tdata), 64'hC1);
    chk("bp_s_tready", 64'(o_s_tready), 64'd0);
    chk("bp_grant", 64'(o_grant), 64'd1);
    repeat (300) @(negedge i_clk);
    chk("bp_tvalid_late", 64'(o_m_tvalid), 64'd1);
    chk("bp_tdata_late", 64'(o_m_tdata), 64'hC1);
    chk("bp_s_tready_late", 64'(o_s_tready), 64'd0);
    chk("bp_busy_late", 64'(o_busy), 64'd1);
    chk("bp_abort_cnt", 64'(o_abort_cnt), 64'd1);
    rdy_mode = 0;
    drain(200);
    chk("bp_abort_pulses", 64'(abort_pulses), 64'd1);

    // Reset mid-packet truncates silently; src0 wins the first grant afterwards.
    sbeat(0, 8'hD1, 0); sbeat(0, 8'hD2, 0); sgap(0, 6); sbeat(0, 8'hD3, 1);
    ebeat(0, 8'hD1, 0, 0, 0); ebeat(0, 8'hD2, 0, 0, 1);
    for (int n = 0; n < 100 && exp_q.size() > 0; n++) @(negedge i_clk);
    chk("pre_rst_left", 64'(exp_q.size()), 64'd0);
    chk("pre_rst_busy", 64'(o_busy), 64'd1);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(o_grant), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_tvalid", 64'(o_m_tvalid), 64'd0);
    chk("mid_rst_s_tready", 64'(o_s_tready), 64'd0);
    chk("mid_rst_abort_cnt", 64'(o_abort_cnt), 64'd0);
    chk("mid_rst_ip", 64'(o_m_ip_adr), 64'd0);
    chk("mid_rst_port", 64'(o_m_port_nbr), 64'd0);
    for (int k = 0; k < NS; k++) src_q[k].delete();
    repeat (3) @(negedge i_clk);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    sbeat(1, 8'hF1, 1);
    sbeat(0, 8'hE1, 0); sbeat(0, 8'hE2, 1);
    ebeat(0, 8'hE1, 0, 0, 0); ebeat(0, 8'hE2, 1, 0, 1);
    ebeat(1, 8'hF1, 1, 0, 2);
    drain(200);
    chk("post_rst_abort_pulses", 64'(abort_pulses), 64'd1);

    // Single-beat packets from both sources alternate strictly.
    sbeat(0, 8'h01, 1); sbeat(0, 8'h02, 1); sbeat(0, 8'h03, 1);
    sbeat(1, 8'h04, 1); sbeat(1, 8'h05, 1); sbeat(1, 8'h06, 1);
    ebeat(0, 8'h01, 1, 0, 0); ebeat(1, 8'h04, 1, 0, 2);
    ebeat(0, 8'h02, 1, 0, 2); ebeat(1, 8'h05, 1, 0, 2);
    ebeat(0, 8'h03, 1, 0, 2); ebeat(1, 8'h06, 1, 0, 2);
    drain(200);
    chk("end_busy", 64'(o_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
